// File: rtl/spin_update_pkg.sv
// Shared types and constants for the Ising spin update unit.
package spin_update_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic SPIN_POS = 1'b1;
  localparam logic SPIN_NEG = 1'b0;

  // The accumulator must hold VECTOR_SIZE full-scale field terms without wrapping.
  function automatic int energy_width(input int vector_size, input int field_width);
    return field_width + $clog2(vector_size);
  endfunction

endpackage

// File: rtl/spin_update_unit_spin_decide.sv
// Combinational spin decision: new spin from sign(h_j) and the signed energy term s*h_j.
module spin_decide
  import spin_update_pkg::*;
#(
  parameter int FIELD_WIDTH  = 13,
  parameter int ENERGY_WIDTH = 21
) (
  input  logic signed [FIELD_WIDTH-1:0]  i_field,
  input  logic                           i_old_spin,
  output logic                           o_new_spin,
  output logic signed [ENERGY_WIDTH-1:0] o_term
);

  logic signed [ENERGY_WIDTH-1:0] w_field_ext;

  always_comb begin
    w_field_ext = ENERGY_WIDTH'(i_field);
    o_new_spin  = i_old_spin;
    if (i_field > 0) begin
      o_new_spin = SPIN_POS;
    end else if (i_field < 0) begin
      o_new_spin = SPIN_NEG;
    end
    o_term = (i_old_spin == SPIN_POS) ? w_field_ext : -w_field_ext;
  end

endmodule

// File: rtl/spin_update_unit.sv
// Spin update stage of the Ising solver: consumes one local field per column and updates spins.
// Optional flip counter enabled with macro SPIN_UPDATE_FLIP_COUNT_EN.
module spin_update_unit
  import spin_update_pkg::*;
#(
  parameter int VECTOR_SIZE  = 256,
  parameter int FIELD_WIDTH  = 13,
  parameter int ENERGY_WIDTH = energy_width(VECTOR_SIZE, FIELD_WIDTH),
  parameter int ASYNC_UPDATE = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_sigma_load_valid,
  input  logic [VECTOR_SIZE-1:0]          i_sigma_load_data,
  input  logic                            i_start,
  input  logic                            i_field_valid,
  output logic                            o_field_ready,
  input  logic signed [FIELD_WIDTH-1:0]   i_field_in,
  output logic [$clog2(VECTOR_SIZE)-1:0]  o_col_idx,
  output logic [VECTOR_SIZE-1:0]          o_sigma_out,
  output logic signed [ENERGY_WIDTH-1:0]  o_energy_out,
  output logic                            o_busy,
  output logic                            o_sweep_done
`ifdef SPIN_UPDATE_FLIP_COUNT_EN
  ,
  output logic [$clog2(VECTOR_SIZE):0]    o_flip_count
`endif
);

  localparam int COL_W = $clog2(VECTOR_SIZE);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(VECTOR_SIZE - 1);

  state_t                         r_state;
  state_t                         w_state_next;
  logic [COL_W-1:0]               r_col;
  logic [VECTOR_SIZE-1:0]         r_sigma;
  logic [VECTOR_SIZE-1:0]         r_shadow;
  logic signed [ENERGY_WIDTH-1:0] r_acc;
  logic signed [ENERGY_WIDTH-1:0] r_energy;
  logic                           w_accept;
  logic                           w_old_spin;
  logic                           w_new_spin;
  logic signed [ENERGY_WIDTH-1:0] w_term;

  assign o_field_ready = (r_state == SWEEP);
  assign o_busy        = (r_state != IDLE);
  assign o_sweep_done  = (r_state == DONE);
  assign o_col_idx     = r_col;
  assign o_sigma_out   = r_sigma;
  assign o_energy_out  = r_energy;

  assign w_accept   = i_field_valid & o_field_ready;
  assign w_old_spin = r_sigma[r_col];

  spin_decide #(
    .FIELD_WIDTH  (FIELD_WIDTH),
    .ENERGY_WIDTH (ENERGY_WIDTH)
  ) u_spin_decide (
    .i_field    (i_field_in),
    .i_old_spin (w_old_spin),
    .o_new_spin (w_new_spin),
    .o_term     (w_term)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = SWEEP;
      SWEEP:   if (w_accept && (r_col == LAST_COL)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_col    <= '0;
      r_sigma  <= '0;
      r_shadow <= '0;
      r_acc    <= '0;
      r_energy <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (i_sigma_load_valid) r_sigma <= i_sigma_load_data;
          // A same-cycle load must be visible to the sweep it starts.
          if (i_start) begin
            r_col    <= '0;
            r_acc    <= '0;
            r_shadow <= i_sigma_load_valid ? i_sigma_load_data : r_sigma;
          end
        end
        SWEEP: begin
          if (w_accept) begin
            r_col <= r_col + COL_W'(1);
            r_acc <= r_acc + w_term;
            if (ASYNC_UPDATE != 0) r_sigma[r_col]  <= w_new_spin;
            else                   r_shadow[r_col] <= w_new_spin;
          end
        end
        DONE: begin
          if (ASYNC_UPDATE == 0) r_sigma <= r_shadow;
          r_energy <= -r_acc;
        end
        default: ;
      endcase
    end
  end

`ifdef SPIN_UPDATE_FLIP_COUNT_EN
  logic [COL_W:0] r_flip_cnt;
  logic [COL_W:0] r_flip_out;

  assign o_flip_count = r_flip_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flip_cnt <= '0;
      r_flip_out <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_flip_cnt <= '0;
      end else if (w_accept && (w_new_spin != w_old_spin)) begin
        r_flip_cnt <= r_flip_cnt + (COL_W + 1)'(1);
      end
      if (r_state == DONE) r_flip_out <= r_flip_cnt;
    end
  end
`endif

endmodule
